blram_arbiter: RTL and testbench
================================

Name: blram_arbiter

Overview:
Two-requester arbiter that shares the single-port blram between the VerySimpleCPU (port 0) and a second master, such as a loader or DMA (port 1). One access is granted per cycle using round-robin priority. A bounded lock lets a master hold the RAM for short atomic sequences. The block tags each granted read so that the one-cycle registered RAM output reaches the correct requester.

Parameters:
SIZE, 14, address width in bits, matching blram SIZE
LOCK_MAX, 16, maximum consecutive grants a locked owner keeps while the other port is requesting (must be at least 1)

Ports:
clk  in  1  system clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
r0_req  in  1  port 0 access request; held until granted
r0_lock  in  1  port 0 asks to keep ownership after this grant
r0_we  in  1  port 0 write enable (0 = read)
r0_addr  in  SIZE  port 0 word address
r0_wdata  in  32  port 0 write data
r0_gnt  out  1  port 0 access accepted this cycle (combinational)
r0_rdata  out  32  read data to port 0 (equals ram_rdata)
r0_rvalid  out  1  r0_rdata valid this cycle (registered)
r1_req, r1_lock, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rdata, r1_rvalid  same widths and meanings for port 1
ram_we  out  1  to blram i_we
ram_addr  out  SIZE  to blram i_addr
ram_wdata  out  32  to blram i_ram_data_in
ram_rdata  in  32  from blram o_ram_data_out; valid one cycle after the address edge

Behaviour:
- Registered state:
  - state: IDLE, LOCK0 or LOCK1
  - prio: 0 = port 0 preferred
  - lock_cnt: 0..LOCK_MAX, saturating
  - r0_rvalid, r1_rvalid
- Reset (rst high at posedge): state=IDLE, prio=0, lock_cnt=0, both rvalid=0.
- While rst is high, r0_gnt=r1_gnt=0 and ram_we=0, regardless of requests.
- Grant is combinational from the current state and requests. At most one gnt is high per cycle.
- Grant in IDLE, or in LOCKn when rn_req=0:
  - Both ports request: grant the port selected by prio.
  - One port requests: grant that port.
  - No port requests: no grant.
- Grant in LOCKn with rn_req=1:
  - Grant n.
  - Exception: if lock_cnt==LOCK_MAX and the other port is requesting, grant the other port (forced release).
- RAM mux:
  - Granted port drives ram_addr, ram_wdata, and ram_we = its we.
  - No grant: ram_we=0, ram_addr=0, ram_wdata=0.
- Read return:
  - At each posedge, rK_rvalid <= gnt_K & ~rK_we.
  - r0_rdata and r1_rdata are wired to ram_rdata.
  - Read latency is exactly 1 cycle from the grant edge. No rvalid is produced for writes.
- Next state after a grant to port n:
  - rn_lock=1: state goes to LOCKn. lock_cnt = 1 if state was not LOCKn, otherwise min(lock_cnt+1, LOCK_MAX).
  - rn_lock=0: state goes to IDLE and lock_cnt=0.
  - In both cases prio <= ~n, so the other port wins the next contested cycle.
- No grant: state goes to IDLE, lock_cnt=0, prio unchanged.
- If the locked owner drops req, the lock ends in that same cycle and the other port may be granted in that cycle.
- If the owner drops only lock while still requesting, it receives that grant and the state then returns to IDLE.
- With no competitor, a locked owner is never forced out; lock_cnt saturates at LOCK_MAX.
- Back-to-back write then read of the same address (from either port) returns the new data, because blram writes at the grant edge.
- Reset mid-lock or mid-read clears state, and the pending rvalid is dropped (0 on the cycle after the reset edge).
- A requester must hold req/we/addr/wdata stable until it sees gnt. The arbiter does not buffer requests.

Test Plan:
- Reset held for 10 cycles with both req=1 -> both gnt=0 and ram_we=0 throughout; after release the first grant goes to port 0 (prio=0).
- Memory[101]=6; port 0 reads addr 101 alone -> r0_gnt=1 in cycle T; r0_rvalid=1, r0_rdata=6 in T+1; r1_rvalid=0.
- Both ports request reads continuously without lock -> grants alternate 0,1,0,1 over 8 cycles; each rvalid follows its own grant by one cycle.
- LOCK_MAX=4; port 0 req+lock continuous, port 1 req continuous -> port 0 granted 4 consecutive cycles, then port 1 granted once, then port 0 resumes.
- Port 1 writes 32'hDEADBEEF to addr 72, then port 0 reads addr 72 on the next cycle -> r0_rdata=32'hDEADBEEF with r0_rvalid=1; no rvalid for the write.
- Port 1 in LOCK1 with a read granted, then rst asserted for 1 cycle -> state=IDLE, r1_rvalid=0 after the reset edge; the next contested grant goes to port 0.

Source files
------------

// File: rtl/blram_arbiter.sv
// Round-robin arbiter sharing one single-port blram between the CPU (port 0)
// and a second master (port 1), with a bounded lock and tagged read return.
module blram_arbiter #(
    parameter int SIZE     = 14,
    parameter int LOCK_MAX = 16,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              r0_req,
    input  logic              r0_lock,
    input  logic              r0_we,
    input  logic [SIZE-1:0]   r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_rvalid,

    input  logic              r1_req,
    input  logic              r1_lock,
    input  logic              r1_we,
    input  logic [SIZE-1:0]   r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_rvalid,

    output logic              ram_we,
    output logic [SIZE-1:0]   ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic             prio, prio_nxt;
    logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;
    logic             lock_full;
    logic             rvld0_p1, rvld1_p1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v >= CNT_MAX)
            return CNT_MAX;
        return v + CNT_ONE;
    endfunction

    assign lock_full = (lock_cnt == CNT_MAX);

    // A locked owner keeps the RAM only while it requests; after LOCK_MAX
    // grants a waiting competitor takes the next slot.
    always_comb begin
        r0_gnt = 1'b0;
        r1_gnt = 1'b0;
        if (!rst) begin
            if (state == LOCK0 && r0_req) begin
                if (lock_full && r1_req)
                    r1_gnt = 1'b1;
                else
                    r0_gnt = 1'b1;
            end else if (state == LOCK1 && r1_req) begin
                if (lock_full && r0_req)
                    r0_gnt = 1'b1;
                else
                    r1_gnt = 1'b1;
            end else if (r0_req && r1_req) begin
                r0_gnt = ~prio;
                r1_gnt = prio;
            end else begin
                r0_gnt = r0_req;
                r1_gnt = r1_req;
            end
        end
    end

    always_comb begin
        state_nxt    = IDLE;
        lock_cnt_nxt = '0;
        prio_nxt     = prio;
        if (r0_gnt) begin
            prio_nxt = 1'b1;
            if (r0_lock) begin
                state_nxt    = LOCK0;
                lock_cnt_nxt = (state == LOCK0) ? sat_inc(lock_cnt) : CNT_ONE;
            end
        end else if (r1_gnt) begin
            prio_nxt = 1'b0;
            if (r1_lock) begin
                state_nxt    = LOCK1;
                lock_cnt_nxt = (state == LOCK1) ? sat_inc(lock_cnt) : CNT_ONE;
            end
        end
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (r0_gnt) begin
            ram_we    = r0_we;
            ram_addr  = r0_addr;
            ram_wdata = r0_wdata;
        end else if (r1_gnt) begin
            ram_we    = r1_we;
            ram_addr  = r1_addr;
            ram_wdata = r1_wdata;
        end
    end

    // Grant edge -> p1: read tag follows the registered RAM output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            prio     <= 1'b0;
            lock_cnt <= '0;
            rvld0_p1 <= 1'b0;
            rvld1_p1 <= 1'b0;
        end else begin
            state    <= state_nxt;
            prio     <= prio_nxt;
            lock_cnt <= lock_cnt_nxt;
            rvld0_p1 <= r0_gnt & ~r0_we;
            rvld1_p1 <= r1_gnt & ~r1_we;
        end
    end

    assign r0_rvalid = rvld0_p1;
    assign r1_rvalid = rvld1_p1;
    assign r0_rdata  = ram_rdata;
    assign r1_rdata  = ram_rdata;

endmodule

// File: tb/tb_blram_arbiter.sv
// Scoreboard bench for blram_arbiter with a small registered RAM model.
module tb_blram_arbiter;

    localparam int SIZE = 14;

    logic            clk = 1'b0;
    logic            rst;
    logic            r0_req, r0_lock, r0_we, r0_gnt, r0_rvalid;
    logic [SIZE-1:0] r0_addr;
    logic [31:0]     r0_wdata, r0_rdata;
    logic            r1_req, r1_lock, r1_we, r1_gnt, r1_rvalid;
    logic [SIZE-1:0] r1_addr;
    logic [31:0]     r1_wdata, r1_rdata;
    logic            ram_we;
    logic [SIZE-1:0] ram_addr;
    logic [31:0]     ram_wdata, ram_rdata;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks   = 0;
    int   failures = 0;

    logic [31:0]  mem [0:255];
    logic [255:0] written;

    always #5 clk = ~clk;

    blram_arbiter #(.SIZE(SIZE), .LOCK_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_lock(r0_lock), .r0_we(r0_we), .r0_addr(r0_addr),
        .r0_wdata(r0_wdata), .r0_gnt(r0_gnt), .r0_rdata(r0_rdata), .r0_rvalid(r0_rvalid),
        .r1_req(r1_req), .r1_lock(r1_lock), .r1_we(r1_we), .r1_addr(r1_addr),
        .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_rdata(r1_rdata), .r1_rvalid(r1_rvalid),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Preloaded contents: address 101 holds 6, others a recognisable pattern.
    function automatic logic [31:0] pat(input logic [7:0] a);
        if (a == 8'd101)
            return 32'd6;
        return {24'hC0FFEE, a};
    endfunction

    // blram stand-in: write at the address edge, registered read output.
    always @(posedge clk) begin
        if (rst) begin
            written <= '0;
        end else if (ram_we) begin
            mem[ram_addr[7:0]]     <= ram_wdata;
            written[ram_addr[7:0]] <= 1'b1;
        end
        ram_rdata <= written[ram_addr[7:0]] ? mem[ram_addr[7:0]] : pat(ram_addr[7:0]);
    end

    task automatic idle_inputs();
        r0_req = 0; r0_lock = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0;
        r1_req = 0; r1_lock = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        r0_req = 1; r0_we = 1; r0_addr = 14'd5; r0_wdata = 32'h1111_2222;
        r1_req = 1; r1_we = 1; r1_addr = 14'd6; r1_wdata = 32'h3333_4444;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({r0_gnt, r1_gnt, ram_we} !== 3'b000) begin
                failures++;
                $display("FAIL reset_gnt cyc%0d: got %b expected 000", i, {r0_gnt, r1_gnt, ram_we});
            end
            checks++;
            if (ram_addr !== '0 || {r0_rvalid, r1_rvalid} !== 2'b00) begin
                failures++;
                $display("FAIL reset_idle cyc%0d: addr=%0h rvalid=%b expected 0/00", i, ram_addr, {r0_rvalid, r1_rvalid});
            end
        end
        rst = 1'b0;
        r0_we = 0; r1_we = 0; r0_addr = 14'd10; r1_addr = 14'd11;
        #1;
        checks++;
        if ({r0_gnt, r1_gnt} !== 2'b10) begin
            failures++;
            $display("FAIL reset_first_gnt: got %b expected 10", {r0_gnt, r1_gnt});
        end
        sb.push_back('{port: 1'b0, data: pat(8'd10)});
        @(posedge clk);
        #1;
        r0_req = 0; r1_req = 0;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL reset_sb: queue empty, expected one read");
        end else begin
            e = sb.pop_front();
            if ({r0_rvalid, r1_rvalid} !== 2'b10 || r0_rdata !== e.data) begin
                failures++;
                $display("FAIL reset_first_read: rvalid=%b data=%h expected 10/%h", {r0_rvalid, r1_rvalid}, r0_rdata, e.data);
            end
        end
    endtask

    task automatic test_single_read();
        do_reset();
        r0_req = 1; r0_addr = 14'd101;
        #1;
        checks++;
        if ({r0_gnt, r1_gnt, ram_we} !== 3'b100 || ram_addr !== 14'd101) begin
            failures++;
            $display("FAIL single_gnt: gnt/we=%b addr=%0d expected 100/101", {r0_gnt, r1_gnt, ram_we}, ram_addr);
        end
        sb.push_back('{port: 1'b0, data: 32'd6});
        @(posedge clk);
        #1;
        r0_req = 0;
        checks++;
        e = sb.pop_front();
        if ({r0_rvalid, r1_rvalid} !== 2'b10 || r0_rdata !== e.data) begin
            failures++;
            $display("FAIL single_read: rvalid=%b data=%h expected 10/%h", {r0_rvalid, r1_rvalid}, r0_rdata, e.data);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({r0_rvalid, r1_rvalid} !== 2'b00) begin
            failures++;
            $display("FAIL single_no_extra: rvalid=%b expected 00", {r0_rvalid, r1_rvalid});
        end
    endtask

    task automatic test_alternate();
        logic p;
        do_reset();
        r0_req = 1; r0_addr = 14'd20;
        r1_req = 1; r1_addr = 14'd40;
        for (int i = 0; i < 8; i++) begin
            #1;
            p = (i % 2 == 1);
            checks++;
            if ({r0_gnt, r1_gnt} !== (p ? 2'b01 : 2'b10)) begin
                failures++;
                $display("FAIL alt_gnt cyc%0d: got %b expected port %0d", i, {r0_gnt, r1_gnt}, p);
            end
            sb.push_back('{port: p, data: pat(p ? 8'd40 : 8'd20)});
            @(posedge clk);
            #1;
            if (i == 7) begin
                r0_req = 0; r1_req = 0;
            end
            checks++;
            e = sb.pop_front();
            if ({r0_rvalid, r1_rvalid} !== (e.port ? 2'b01 : 2'b10) ||
                (e.port ? r1_rdata : r0_rdata) !== e.data) begin
                failures++;
                $display("FAIL alt_read cyc%0d: rvalid=%b data=%h expected port %0d/%h",
                         i, {r0_rvalid, r1_rvalid}, ram_rdata, e.port, e.data);
            end
        end
    endtask

    task automatic test_lock();
        logic p;
        do_reset();
        r0_req = 1; r0_lock = 1; r0_addr = 14'd30;
        r1_req = 1; r1_addr = 14'd50;
        for (int i = 0; i < 11; i++) begin
            #1;
            p = (i % 5 == 4);
            checks++;
            if ({r0_gnt, r1_gnt} !== (p ? 2'b01 : 2'b10)) begin
                failures++;
                $display("FAIL lock_gnt cyc%0d: got %b expected port %0d", i, {r0_gnt, r1_gnt}, p);
            end
            sb.push_back('{port: p, data: pat(p ? 8'd50 : 8'd30)});
            @(posedge clk);
            #1;
            if (i == 10) idle_inputs();
            checks++;
            e = sb.pop_front();
            if ({r0_rvalid, r1_rvalid} !== (e.port ? 2'b01 : 2'b10) ||
                (e.port ? r1_rdata : r0_rdata) !== e.data) begin
                failures++;
                $display("FAIL lock_read cyc%0d: rvalid=%b data=%h expected port %0d/%h",
                         i, {r0_rvalid, r1_rvalid}, ram_rdata, e.port, e.data);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        r1_req = 1; r1_we = 1; r1_addr = 14'd72; r1_wdata = 32'hDEADBEEF;
        #1;
        checks++;
        if ({r0_gnt, r1_gnt, ram_we} !== 3'b011 || ram_addr !== 14'd72 || ram_wdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL b2b_write: gnt/we=%b addr=%0d wdata=%h expected 011/72/deadbeef",
                     {r0_gnt, r1_gnt, ram_we}, ram_addr, ram_wdata);
        end
        @(posedge clk);
        #1;
        r1_req = 0; r1_we = 0;
        r0_req = 1; r0_addr = 14'd72;
        #1;
        checks++;
        if ({r0_rvalid, r1_rvalid} !== 2'b00) begin
            failures++;
            $display("FAIL b2b_write_rvalid: got %b expected 00", {r0_rvalid, r1_rvalid});
        end
        checks++;
        if ({r0_gnt, r1_gnt, ram_we} !== 3'b100) begin
            failures++;
            $display("FAIL b2b_read_gnt: got %b expected 100", {r0_gnt, r1_gnt, ram_we});
        end
        sb.push_back('{port: 1'b0, data: 32'hDEADBEEF});
        @(posedge clk);
        #1;
        r0_req = 0;
        checks++;
        e = sb.pop_front();
        if ({r0_rvalid, r1_rvalid} !== 2'b10 || r0_rdata !== e.data) begin
            failures++;
            $display("FAIL b2b_read: rvalid=%b data=%h expected 10/%h", {r0_rvalid, r1_rvalid}, r0_rdata, e.data);
        end
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        r1_req = 1; r1_lock = 1; r1_addr = 14'd90;
        #1;
        checks++;
        if ({r0_gnt, r1_gnt} !== 2'b01) begin
            failures++;
            $display("FAIL midrst_lock_gnt: got %b expected 01", {r0_gnt, r1_gnt});
        end
        sb.push_back('{port: 1'b1, data: pat(8'd90)});
        @(posedge clk);
        #1;
        rst = 1'b1;
        r0_req = 1; r0_addr = 14'd91;
        #1;
        checks++;
        if ({r0_gnt, r1_gnt, ram_we} !== 3'b000) begin
            failures++;
            $display("FAIL midrst_gnt: got %b expected 000", {r0_gnt, r1_gnt, ram_we});
        end
        checks++;
        e = sb.pop_front();
        if ({r0_rvalid, r1_rvalid} !== 2'b01 || r1_rdata !== e.data) begin
            failures++;
            $display("FAIL midrst_read: rvalid=%b data=%h expected 01/%h", {r0_rvalid, r1_rvalid}, r1_rdata, e.data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({r0_rvalid, r1_rvalid} !== 2'b00) begin
            failures++;
            $display("FAIL midrst_rvalid: got %b expected 00", {r0_rvalid, r1_rvalid});
        end
        checks++;
        if ({r0_gnt, r1_gnt} !== 2'b10) begin
            failures++;
            $display("FAIL midrst_next_gnt: got %b expected 10", {r0_gnt, r1_gnt});
        end
        idle_inputs();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_alternate();
        test_lock();
        test_back_to_back();
        test_reset_mid_lock();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
